// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and framing constants for prog_loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_idle_timer.sv
// rtl/prog_loader_idle_timer.sv - saturating idle-cycle counter with clear and expired flag
module idle_timer #(
  parameter int LIMIT = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CW'(LIMIT));
  assign o_expired  = w_at_limit;

  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_count <= '0;
    end else if (!w_at_limit) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to program RAM writer with checksum and CPU hold
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter int         DATA_W  = 32,
  parameter logic [7:0] MAGIC   = MAGIC_DEFAULT,
  parameter int         TIMEOUT = 1_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_words_left;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [DATA_W-1:0]   r_asm;
  logic [7:0]          r_sum;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_error;

  logic                w_hs;
  logic                w_expired;
  logic                w_timeout;
  logic                w_last_byte;
  logic                w_wr_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic [DATA_W-1:0]   w_asm_nxt;

  assign in_ready    = 1'b1;
  assign w_hs        = in_valid;
  assign w_timeout   = (r_state != ST_IDLE) && w_expired;
  assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign w_asm_nxt   = {r_asm[DATA_W-9:0], in_data};

  idle_timer #(
    .LIMIT(TIMEOUT)
  ) u_idle_timer (
    .CLK      (CLK),
    .RST      (RST),
    .i_clear  (w_hs || (r_state == ST_IDLE)),
    .o_expired(w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout wins over a byte arriving in the same cycle: the frame is already dead.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = 1'b1;
    end else if (w_hs) begin
      case (r_state)
        ST_IDLE:   if (in_data == MAGIC) w_state_nxt = ST_LEN_HI;
        ST_LEN_HI: w_state_nxt = ST_LEN_LO;
        ST_LEN_LO: w_state_nxt = ({r_len_hi, in_data} == 16'd0) ? ST_CHECK : ST_DATA;
        ST_DATA: begin
          if (w_last_byte) begin
            w_wr_nxt = 1'b1;
            if (r_words_left == 16'd1) w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          w_state_nxt = ST_IDLE;
          if (in_data == r_sum) w_done_nxt = 1'b1;
          else                  w_err_nxt  = 1'b1;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_len_hi     <= '0;
      r_words_left <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_asm        <= '0;
      r_sum        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_wr_en <= w_wr_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_err_nxt;
      if (w_done_nxt) r_cpu_hold <= 1'b0;
      if (w_hs && !w_timeout) begin
        case (r_state)
          ST_IDLE: begin
            if (in_data == MAGIC) begin
              r_sum      <= '0;
              r_byte_idx <= '0;
              r_word_idx <= '0;
              r_cpu_hold <= 1'b1;
            end
          end
          ST_LEN_HI: r_len_hi <= in_data;
          ST_LEN_LO: r_words_left <= {r_len_hi, in_data};
          ST_DATA: begin
            r_asm      <= w_asm_nxt;
            r_sum      <= r_sum + in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) begin
              r_wr_addr    <= r_word_idx;
              r_wr_data    <= w_asm_nxt;
              r_word_idx   <= r_word_idx + ADDR_W'(1);
              r_words_left <= r_words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always #5 CLK = ~CLK;

  prog_loader #(
    .ADDR_W (16),
    .DATA_W (32),
    .MAGIC  (8'hA5),
    .TIMEOUT(16)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always @(negedge CLK) begin
    if (wr_en) wr_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
  end

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error} !==
        {1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_outputs got rdy=%b wr=%b a=%h d=%h hold=%b busy=%b done=%b err=%b want rdy=1 rest=0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error);
    else n_pass++;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // A5 00 02 | 00000007 | 04000008 | chk ; payload sum is 0x13.
  task automatic two_word_frame(input string tag, input logic [7:0] chk, input bit good);
    logic [7:0]  pl [8];
    logic [31:0] ew [2];
    pl = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h04, 8'h00, 8'h00, 8'h08};
    ew = '{32'h0000_0007, 32'h0400_0008};
    clear_counts();
    send(8'hA5);
    n_total++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1)
      $display("FAIL %s_after_magic busy=%b hold=%b want 1 1", tag, busy, cpu_hold);
    else n_pass++;
    send(8'h00);
    send(8'h02);
    for (int i = 0; i < 8; i++) begin
      send(pl[i]);
      n_total++;
      if (i % 4 == 3) begin
        if (wr_en !== 1'b1 || wr_addr !== 16'(i / 4) || wr_data !== ew[i / 4])
          $display("FAIL %s_write%0d wr=%b a=%h d=%h want 1 %h %h", tag, i / 4, wr_en, wr_addr,
                   wr_data, 16'(i / 4), ew[i / 4]);
        else n_pass++;
      end else begin
        if (wr_en !== 1'b0) $display("FAIL %s_no_write_b%0d wr=%b want 0", tag, i, wr_en);
        else n_pass++;
      end
    end
    send(chk);
    n_total++;
    if (done !== good || error !== !good || cpu_hold !== !good || busy !== 1'b0)
      $display("FAIL %s_end done=%b err=%b hold=%b busy=%b want %b %b %b 0", tag, done, error,
               cpu_hold, busy, good, !good, !good);
    else n_pass++;
    @(posedge CLK);
    #1;
    n_total++;
    if (done !== 1'b0 || error !== 1'b0 || wr_cnt !== 2 || done_cnt !== int'(good) ||
        err_cnt !== int'(!good))
      $display("FAIL %s_totals done=%b err=%b writes=%0d dones=%0d errs=%0d want 0 0 2 %0d %0d",
               tag, done, error, wr_cnt, done_cnt, err_cnt, good, !good);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    two_word_frame("good", 8'h13, 1'b1);
  endtask

  task automatic test_bad_checksum();
    two_word_frame("badchk", 8'h18, 1'b0);
  endtask

  task automatic test_zero_length();
    clear_counts();
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    n_total++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || wr_cnt !== 0)
      $display("FAIL zero_len done=%b err=%b hold=%b writes=%0d want 1 0 0 0", done, error,
               cpu_hold, wr_cnt);
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_garbage_then_frame();
    send(8'h12);
    send(8'hFF);
    n_total++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0)
      $display("FAIL garbage_idle busy=%b hold=%b want 0 0", busy, cpu_hold);
    else n_pass++;
    two_word_frame("garbage", 8'h13, 1'b1);
  endtask

  task automatic test_timeout();
    int waited;
    clear_counts();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (error) begin
        waited = i;
        break;
      end
    end
    n_total++;
    if (waited !== 17)
      $display("FAIL timeout_latency cycles=%0d want 17", waited);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || cpu_hold !== 1'b1 || wr_cnt !== 0 || done_cnt !== 0)
      $display("FAIL timeout_state busy=%b hold=%b writes=%0d dones=%0d want 0 1 0 0", busy,
               cpu_hold, wr_cnt, done_cnt);
    else n_pass++;
    @(posedge CLK);
    #1;
    two_word_frame("after_timeout", 8'h13, 1'b1);
  endtask

  task automatic test_reset_mid_data();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    n_total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error} !==
        {1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL midreset_outputs rdy=%b wr=%b a=%h d=%h hold=%b busy=%b done=%b err=%b want 1 0 0 0 0 0 0 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error);
    else n_pass++;
    RST = 1'b0;
    clear_counts();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 16'h0000 || wr_data !== 32'h1122_3344)
      $display("FAIL midreset_reload wr=%b a=%h d=%h want 1 0000 11223344", wr_en, wr_addr, wr_data);
    else n_pass++;
    send(8'hAA);
    n_total++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_cnt !== 1)
      $display("FAIL midreset_done done=%b hold=%b writes=%0d want 1 0 1", done, cpu_hold, wr_cnt);
    else n_pass++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_length();
    test_garbage_then_frame();
    test_timeout();
    test_reset_mid_data();
    n_total++;
    if (both_cnt !== 0) $display("FAIL done_and_error_together count=%0d want 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
